instr_encoder: RTL
==================

// Module: instr_encoder
// PURPOSE
//  Inverse of the opcode decoder. Packs ALU-op requests (op select, rd, rs1, rs2, imm) into RV32 R/I-type words.
//  Queues the words in a small FIFO and streams them with valid/ready to the instruction-memory write port.
//  Each word is tagged with an auto-incrementing byte address.
//  Used by the bench/loader to fill instruction memory for the pipeline.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of 2, >=2
//  ADDR_W  32  width of addr_o / count_o
// PORTS
//  clk_i        in   1       clock, rising edge
//  rst_i        in   1       async, active-high reset
//  in_valid_i   in   1       request valid
//  in_ready_o   out  1       FIFO can accept (= !full)
//  op_sel_i     in   3       0 ADD,1 SUB,2 AND,3 OR,4 MUL,5 ADDI,6-7 illegal
//  rd_i         in   5       destination register
//  rs1_i        in   5       source register 1
//  rs2_i        in   5       source register 2 (ignored for ADDI)
//  imm_i        in   12      immediate (ADDI only)
//  out_valid_o  out  1       instr_o/addr_o valid
//  out_ready_i  in   1       sink accepts word
//  instr_o      out  32      encoded instruction
//  addr_o       out  ADDR_W  byte address of instr_o
//  count_o      out  ADDR_W  words delivered since reset
//  err_o        out  1       illegal-op pulse; tied 0 without the macro
// BEHAVIOUR
//  - Reset (async, any cycle, mid-transfer included): FIFO empty.
//    out_valid_o=0, instr_o=0, addr_o=0, count_o=0, err_o=0, in_ready_o=1. Queued data is lost.
//  - Push on in_valid_i & in_ready_o. Encoding is combinational; the word is written into the FIFO.
//  - Latency: a word accepted in cycle N gives out_valid_o=1 in N+1 (registered head). No bypass.
//  - Pop on out_valid_o & out_ready_i. addr_o += 4 and count_o += 1 on each pop; both wrap modulo 2^ADDR_W.
//  - instr_o/addr_o hold stable while out_valid_o & !out_ready_i.
//  - Full: in_ready_o=0. A simultaneous pop does not re-enable in_ready_o in the same cycle.
//  - Empty: out_valid_o=0 and instr_o holds its last value.
//  - Simultaneous push+pop when neither full nor empty: occupancy unchanged, both complete.
//  - R-type {f7,rs2,rs1,f3,rd,7'b0110011}:
//    ADD f7=0000000 f3=000; SUB f7=0100000 f3=000; AND f7=0 f3=111; OR f7=0 f3=110; MUL f7=0000001 f3=000.
//  - I-type ADDI {imm[11:0],rs1,3'b000,rd,7'b0010011}.
//  - Control FSM: 2-bit occupancy state EMPTY / PARTIAL / FULL.
//    Transitions follow push-only (+1), pop-only (-1), or both (hold).
//    Pointers wrap at DEPTH.
// CONFIGURATION
//  INSTR_ENC_ILLEGAL_CHK_EN defined: illegal op_sel is accepted, nothing is pushed, err_o=1 for one cycle after acceptance.
//  Not defined: illegal op_sel is encoded as NOP 0x00000013 and pushed normally; err_o=0.
// STRUCTURE
//  - Opcode, funct3, funct7 and op_sel constants go in the shared opcodes.vh header, next to the decoder's opcode/ALUOp defines.
//  - Sub-module instr_fifo (DEPTH x 32+0, ptrs, full/empty) holds storage and occupancy.
//  - Encode mux and address/count counters live at top level.
// TESTING
//  1. ADD rd=3 rs1=1 rs2=2, out_ready_i=1 -> next cycle instr_o=0x002081B3, addr_o=0; after pop addr_o=4, count_o=1.
//  2. SUB 3,1,2 ; MUL 4,1,2 ; ADDI rd=5 rs1=0 imm=0xFFF back-to-back
//     -> 0x402081B3, 0x02208233, 0xFFF00293 in order at addr 0,4,8.
//  3. out_ready_i=0, push DEPTH words -> in_ready_o=0 after 4th; words held stable.
//     Release ready -> all 4 delivered in order, no loss or duplication.
//  4. Full FIFO, push+pop same cycle -> pop completes, push refused, in_ready_o=1 next cycle.
//  5. op_sel=7 -> with macro: err_o pulse, nothing queued; without macro: 0x00000013 delivered.
//  6. Assert rst_i with 2 words queued -> out_valid_o=0, addr_o=0, count_o=0 immediately (asynchronous), before the next clock edge.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: opcode/funct constants, occupancy states and the R/I-type encoder shared by instr_encoder
package instr_encoder_pkg;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_ADDI} op_e;
  typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} occ_e;
  localparam logic [6:0] OPC_REG = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;
  localparam logic [6:0] F7_MUL = 7'b0000001;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR = 3'b110;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  function automatic logic is_illegal(input logic [2:0] op);
    return op > OP_ADDI;
  endfunction
  // Illegal selects fall back to the canonical NOP (ADDI x0,x0,0)
  function automatic logic [31:0] enc_instr(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2, input logic [11:0] imm);
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = op == OP_SUB ? F7_SUB : op == OP_MUL ? F7_MUL : F7_BASE;
    f3 = op == OP_AND ? F3_AND : op == OP_OR ? F3_OR : F3_ADD;
    return is_illegal(op) ? INSTR_NOP : op == OP_ADDI ? {imm, rs1, F3_ADD, rd, OPC_IMM} : {f7, rs2, rs1, f3, rd, OPC_REG};
  endfunction
endpackage

// File: rtl/instr_encoder_fifo.sv
// instr_encoder_fifo: DEPTH x 32 word FIFO with EMPTY/PARTIAL/FULL occupancy FSM
//   clk_i, rst_i (async, active-high)
//   push_i/data_i  write side; caller guarantees !full_o
//   pop_i/data_o   read side; caller guarantees !empty_o; data_o is the head word
//   full_o, empty_o occupancy flags, registered
module instr_encoder_fifo import instr_encoder_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        full_o,
  output logic        empty_o
);
  localparam int PW = $clog2(DEPTH);
  logic [31:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  occ_e r_state;
  assign full_o = r_state == ST_FULL;
  assign empty_o = r_state == ST_EMPTY;
  assign data_o = r_mem[r_rd];
  // Pointers wrap naturally at DEPTH (power of 2); equal pointers are disambiguated by the state
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_wr <= '0;
      r_rd <= '0;
      r_state <= ST_EMPTY;
    end else begin
      if (push_i) r_wr <= r_wr + 1'b1;
      if (pop_i) r_rd <= r_rd + 1'b1;
      if (push_i && !pop_i) r_state <= PW'(r_wr + 1'b1) == r_rd ? ST_FULL : ST_PARTIAL;
      else if (pop_i && !push_i) r_state <= PW'(r_rd + 1'b1) == r_wr ? ST_EMPTY : ST_PARTIAL;
    end
  always_ff @(posedge clk_i)
    if (push_i) r_mem[r_wr] <= data_i;
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs ALU-op requests into RV32 R/I-type words and streams them with byte addresses
//   clk_i, rst_i (async, active-high)
//   in_valid_i/in_ready_o, op_sel_i, rd_i, rs1_i, rs2_i, imm_i   request side
//   out_valid_o/out_ready_i, instr_o, addr_o                     instruction-memory write side
//   count_o  words delivered since reset; err_o illegal-op pulse
//   INSTR_ENC_ILLEGAL_CHK_EN: drop illegal op_sel and pulse err_o; otherwise push NOP, err_o=0
module instr_encoder import instr_encoder_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [2:0]        op_sel_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [11:0]       imm_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [ADDR_W-1:0] count_o,
  output logic              err_o
);
  logic w_push, w_pop, w_full, w_empty;
  logic [31:0] w_word, w_head, r_last;
  logic [ADDR_W-1:0] r_addr, r_count;
  assign w_word = enc_instr(op_sel_i, rd_i, rs1_i, rs2_i, imm_i);
  assign in_ready_o = !w_full;
  assign out_valid_o = !w_empty;
  assign w_pop = out_valid_o & out_ready_i;
  // When drained, present the last delivered word rather than stale storage
  assign instr_o = w_empty ? r_last : w_head;
  assign addr_o = r_addr;
  assign count_o = r_count;
`ifdef INSTR_ENC_ILLEGAL_CHK_EN
  logic r_err;
  assign w_push = in_valid_i & in_ready_o & !is_illegal(op_sel_i);
  assign err_o = r_err;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_err <= 1'b0;
    else r_err <= in_valid_i & in_ready_o & is_illegal(op_sel_i);
`else
  assign w_push = in_valid_i & in_ready_o;
  assign err_o = 1'b0;
`endif
  instr_encoder_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (w_push),
    .pop_i  (w_pop),
    .data_i (w_word),
    .data_o (w_head),
    .full_o (w_full),
    .empty_o(w_empty)
  );
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_last <= '0;
      r_addr <= '0;
      r_count <= '0;
    end else if (w_pop) begin
      r_last <= w_head;
      r_addr <= r_addr + ADDR_W'(4);
      r_count <= r_count + 1'b1;
    end
endmodule
